// File: rtl/pool_frame_buffer_pkg.sv
// pool_frame_buffer_pkg: shared types and sizing helpers for the pooled-frame ping-pong buffer
package pool_frame_buffer_pkg;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
    typedef enum logic {IDLE, STREAM} rd_state_t;

    localparam int NUM_BANKS = 2;

    function automatic int pool_depth(input int m, input int p);
        return (m / p) * (m / p);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic occupied(input bank_state_t s);
        return s == FULL || s == DRAINING;
    endfunction

endpackage

// File: rtl/pool_frame_buffer_bank.sv
// pool_frame_buffer_bank: one frame bank, DEPTH x WIDTH register file with sync write and async read
module pool_frame_buffer_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is only read after being written, so it carries no reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_frame_buffer.sv
// pool_frame_buffer: ping-pong capture of pooled frames replayed on a valid/ready stream with last flag
module pool_frame_buffer
    import pool_frame_buffer_pkg::*;
#(
    parameter int M     = 12,
    parameter int P     = 3,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             external_reset,
    input  logic             ce,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_end_op,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [1:0]       frames_pending,
    output logic             overflow,
    output logic             frame_err
);

    localparam int DEPTH = pool_depth(M, P);
    localparam int AW    = ptr_width(DEPTH);
    localparam int CW    = cnt_width(DEPTH);

    bank_state_t      bs     [NUM_BANKS];
    bank_state_t      bs_nxt [NUM_BANKS];
    logic [CW-1:0]    cnt    [NUM_BANKS];
    logic [WIDTH-1:0] rd_data[NUM_BANKS];
    rd_state_t        rd_state;
    logic             wbank, rbank;
    logic [AW-1:0]    wptr, rptr;
    logic             wr_ok, drop, close_full, err, close;
    logic [CW-1:0]    wcnt;
    logic             hs, fin, step, start, chain, ld, ld_bank;
    logic [AW-1:0]    ld_addr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pool_frame_buffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk  (clk),
            .we   (wr_ok && wbank == 1'(b)),
            .waddr(wptr),
            .wdata(in_data),
            .raddr(ld_addr),
            .rdata(rd_data[b])
        );
    end

    // Write side: accept words only into a bank not holding a completed frame; close on DEPTH or early end_op
    always_comb begin
        wr_ok      = ce && in_valid && !occupied(bs[wbank]);
        drop       = ce && in_valid && occupied(bs[wbank]);
        wcnt       = CW'(wptr) + CW'(wr_ok);
        close_full = wr_ok && wcnt == CW'(DEPTH);
        err        = ce && in_end_op && !close_full && wcnt != '0;
        close      = close_full || err;
    end

    // Read side: decide which word (if any) is loaded into the output register this edge
    always_comb begin
        hs      = m_valid && m_ready;
        fin     = rd_state == STREAM && hs && m_last;
        step    = rd_state == STREAM && hs && !m_last;
        start   = rd_state == IDLE && bs[rbank] == FULL;
        chain   = fin && bs[!rbank] == FULL;
        ld      = start || chain || step;
        ld_bank = chain ? !rbank : rbank;
        ld_addr = step ? rptr : '0;
    end

    // Bank lifecycle; write and read sides only ever touch banks in disjoint states, so they never collide
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bs_nxt[i] = bs[i];
            if (wr_ok && wbank == 1'(i) && bs[i] == EMPTY) bs_nxt[i] = FILLING;
            if (close && wbank == 1'(i)) bs_nxt[i] = FULL;
            if (fin && rbank == 1'(i)) bs_nxt[i] = EMPTY;
            if ((start || chain) && ld_bank == 1'(i)) bs_nxt[i] = DRAINING;
        end
    end

    // Write pointer, bank states and per-bank word counts
    always_ff @(posedge clk or negedge external_reset) begin
        if (!external_reset) begin
            bs[0] <= EMPTY;
            bs[1] <= EMPTY;
            cnt[0] <= '0;
            cnt[1] <= '0;
            wbank <= 1'b0;
            wptr  <= '0;
        end else if (clear) begin
            bs[0] <= EMPTY;
            bs[1] <= EMPTY;
            cnt[0] <= '0;
            cnt[1] <= '0;
            wbank <= 1'b0;
            wptr  <= '0;
        end else begin
            bs[0] <= bs_nxt[0];
            bs[1] <= bs_nxt[1];
            if (close) begin
                cnt[wbank] <= wcnt;
                wbank      <= !wbank;
                wptr       <= '0;
            end else if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    // Output stream register: one beat per handshake, held while stalled, chained across banks without a gap
    always_ff @(posedge clk or negedge external_reset) begin
        if (!external_reset) begin
            rd_state <= IDLE;
            rbank    <= 1'b0;
            rptr     <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else if (clear) begin
            rd_state <= IDLE;
            rbank    <= 1'b0;
            rptr     <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            if (ld) begin
                m_data   <= rd_data[ld_bank];
                m_last   <= (CW'(ld_addr) + CW'(1)) == cnt[ld_bank];
                m_valid  <= 1'b1;
                rptr     <= ld_addr + 1'b1;
                rd_state <= STREAM;
            end else if (fin) begin
                m_valid  <= 1'b0;
                m_last   <= 1'b0;
                rptr     <= '0;
                rd_state <= IDLE;
            end
            if (fin) rbank <= !rbank;
        end
    end

    // Sticky error flags and occupancy taken from the next bank states
    always_ff @(posedge clk or negedge external_reset) begin
        if (!external_reset) begin
            overflow       <= 1'b0;
            frame_err      <= 1'b0;
            frames_pending <= '0;
        end else if (clear) begin
            overflow       <= 1'b0;
            frame_err      <= 1'b0;
            frames_pending <= '0;
        end else begin
            overflow       <= overflow | drop;
            frame_err      <= frame_err | err;
            frames_pending <= 2'(occupied(bs_nxt[0])) + 2'(occupied(bs_nxt[1]));
        end
    end

endmodule

// File: tb/tb_pool_frame_buffer.sv
// tb_pool_frame_buffer: table-driven, directed and random checks against a frame-queue reference model
module tb_pool_frame_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        external_reset = 1'b0;
    logic        ce = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_end_op = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [1:0]  frames_pending;
    logic        overflow;
    logic        frame_err;

    always #5 clk = ~clk;

    pool_frame_buffer #(.M(12), .P(3), .WIDTH(16)) dut (
        .clk           (clk),
        .external_reset(external_reset),
        .ce            (ce),
        .clear         (clear),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_end_op     (in_end_op),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .frames_pending(frames_pending),
        .overflow      (overflow),
        .frame_err     (frame_err)
    );

    typedef struct {
        bit ce;
        bit v;
        int d;
        bit r;
        bit ev;
        int ed;
        bit el;
        int ep;
    } vec_t;

    vec_t tbl[33];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats_seen = 0;

    // Reference model: completed frames as a flat word queue plus per-frame lengths and completion cycle
    int words[$];
    int lens[$];
    int done_at[$];
    int cur[$];
    int beat = 0;
    bit ovf = 0;
    bit ferr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        words.delete();
        lens.delete();
        done_at.delete();
        cur.delete();
        beat = 0;
        ovf  = 0;
        ferr = 0;
    endtask

    task automatic cycle(input bit c, input bit v, input bit e, input int d, input bit r, input bit clr = 0);
        bit pv, pl;
        int pd, pend;
        ce = c; in_valid = v; in_end_op = e; in_data = 16'(d); m_ready = r; clear = clr;
        pv = m_valid; pl = m_last; pd = int'(m_data);
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            model_reset();
        end else begin
            pend = lens.size();
            if (pv && r) begin
                if (words.size() == 0) begin
                    chk("spurious_beat", int'(pv), 0);
                end else begin
                    chk("beat_data", pd, words.pop_front());
                    beat++;
                    beats_seen++;
                    chk("beat_last", int'(pl), int'(beat == lens[0]));
                    if (beat == lens[0]) begin
                        void'(lens.pop_front());
                        void'(done_at.pop_front());
                        beat = 0;
                    end
                end
            end
            if (c && v) begin
                if (pend == 2) ovf = 1;
                else cur.push_back(d & 16'hFFFF);
            end
            if (cur.size() == DEPTH || (c && e && cur.size() > 0)) begin
                if (cur.size() != DEPTH) ferr = 1;
                lens.push_back(cur.size());
                done_at.push_back(cyc);
                foreach (cur[k]) words.push_back(cur[k]);
                cur.delete();
            end
        end
        chk("frames_pending", int'(frames_pending), lens.size());
        chk("overflow", int'(overflow), int'(ovf));
        chk("frame_err", int'(frame_err), int'(ferr));
        chk("m_valid", int'(m_valid), (lens.size() > 0) ? int'(done_at[0] < cyc) : 0);
        if (!clr && pv && !r) begin
            chk("hold_valid", int'(m_valid), 1);
            chk("hold_data", int'(m_data), pd);
            chk("hold_last", int'(m_last), int'(pl));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_m_last"}, int'(m_last), 0);
        chk({tag, "_pending"}, int'(frames_pending), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        int b0;
        for (int i = 0; i < 33; i++) begin
            tbl[i].ce = 1;
            tbl[i].v  = i < 16;
            tbl[i].d  = i + 1;
            tbl[i].r  = 1;
            tbl[i].ev = i >= 16 && i < 32;
            tbl[i].ed = i - 15;
            tbl[i].el = i == 31;
            tbl[i].ep = (i >= 15 && i < 32) ? 1 : 0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        external_reset = 1'b1;

        for (int i = 0; i < 33; i++) begin
            cycle(tbl[i].ce, tbl[i].v, 1'b0, tbl[i].d, tbl[i].r);
            chk("tbl_valid", int'(m_valid), int'(tbl[i].ev));
            chk("tbl_pending", int'(frames_pending), tbl[i].ep);
            if (tbl[i].ev) begin
                chk("tbl_data", int'(m_data), tbl[i].ed);
                chk("tbl_last", int'(m_last), int'(tbl[i].el));
            end
        end

        b0 = beats_seen;
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 'h100 + i, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200 && beats_seen - b0 < 16; i++) cycle(1, 0, 0, 0, 1'($urandom_range(0, 1)));
        chk("bp_beats", beats_seen - b0, 16);
        cycle(1, 0, 0, 0, 1);

        for (int i = 1; i <= 48; i++) cycle(1, 1, 0, i, 0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_pending", int'(frames_pending), 2);
        b0 = beats_seen;
        repeat (40) cycle(1, 0, 0, 0, 1);
        chk("ovf_beats", beats_seen - b0, 32);

        cycle(0, 0, 0, 0, 0, 1);
        b0 = beats_seen;
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 'h400 + i, 1);
        cycle(1, 0, 1, 0, 1);
        chk("short_err", int'(frame_err), 1);
        repeat (15) cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 'h500 + i, 1);
        repeat (20) cycle(1, 0, 0, 0, 1);
        chk("short_beats", beats_seen - b0, 26);

        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 'h200 + i, 0);
        for (int i = 0; i < 15; i++) cycle(1, 1, 0, 'h300 + i, 0);
        repeat (15) cycle(1, 0, 0, 0, 1);
        chk("sim_pre_last", int'(m_last), 1);
        cycle(1, 1, 0, 'h30F, 1);
        chk("sim_gap_valid", int'(m_valid), 0);
        chk("sim_gap_pending", int'(frames_pending), 1);
        cycle(1, 0, 0, 0, 1);
        chk("sim_first_valid", int'(m_valid), 1);
        chk("sim_first_data", int'(m_data), 'h300);
        chk("sim_first_pending", int'(frames_pending), 1);
        repeat (20) cycle(1, 0, 0, 0, 1);

        cycle(0, 0, 0, 0, 0, 1);
        repeat (800) begin
            cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0), int'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 399) == 0));
        end
        repeat (40) cycle(1, 0, 0, 0, 1);

        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 'h600 + i, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 'h700 + i, 1);
        #2;
        external_reset = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        @(negedge clk);
        external_reset = 1'b1;
        repeat (5) cycle(1, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
